// File: rtl/tt_pwm_pkg.sv
// Shared constants for the tt_pwm_bank register map.
package tt_pwm_pkg;

  localparam int unsigned ADDR_PERIOD    = 0;
  localparam int unsigned ADDR_DUTY_BASE = 1;

  // The enable-mask register sits directly after the last duty register.
  function automatic int unsigned addr_mask(input int unsigned nch);
    return nch + 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty and mask, plus the registered compare.
module pwm_channel
  import tt_pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] cnt,
  input  logic             duty_we,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mask_we,
  input  logic             mask_din,
  input  logic             transfer,
  output logic             pwm_out
);

  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic             mask_sh_q, mask_sh_d;
  logic             mask_act_q, mask_act_d;
  logic             pwm_q, pwm_d;

  // Transfer takes the shadow value held before this edge; a same-cycle write only reaches the shadow.
  always_comb begin
    duty_sh_d  = duty_we  ? wr_data  : duty_sh_q;
    mask_sh_d  = mask_we  ? mask_din : mask_sh_q;
    duty_act_d = transfer ? duty_sh_q : duty_act_q;
    mask_act_d = transfer ? mask_sh_q : mask_act_q;
    pwm_d      = ena & mask_act_q & (cnt < duty_act_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      mask_sh_q  <= 1'b0;
      mask_act_q <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      mask_sh_q  <= mask_sh_d;
      mask_act_q <= mask_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/tt_pwm_bank.sv
// Multi-channel PWM bank: shared period counter, shadowed config, commit applied at period wrap.
module tt_pwm_bank
  import tt_pwm_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = $clog2(NCH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              commit,
  output logic              commit_pending,
  output logic              wrap_tick,
  output logic [NCH-1:0]    pwm_out
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic             pending_q, pending_d;
  logic             wrap_tick_q, wrap_tick_d;

  logic             wrap;
  logic             transfer;
  logic             period_we;
  logic             mask_we;

  assign wrap      = ena & (cnt_q == period_act_q);
  assign transfer  = wrap & pending_q;
  assign period_we = wr_en & (wr_addr == ADDR_W'(ADDR_PERIOD));
  assign mask_we   = wr_en & (wr_addr == ADDR_W'(addr_mask(NCH)));

  // A commit in the transfer cycle re-arms pending for the following wrap.
  always_comb begin
    cnt_d        = cnt_q;
    period_sh_d  = period_sh_q;
    period_act_d = period_act_q;
    pending_d    = pending_q;
    wrap_tick_d  = wrap;
    if (ena) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    if (period_we) begin
      period_sh_d = wr_data;
    end
    if (transfer) begin
      period_act_d = period_sh_q;
      pending_d    = 1'b0;
    end
    if (commit) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      pending_q    <= 1'b0;
      wrap_tick_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      pending_q    <= pending_d;
      wrap_tick_q  <= wrap_tick_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic duty_we;
    assign duty_we = wr_en & (wr_addr == ADDR_W'(ADDR_DUTY_BASE + i));

    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .cnt     (cnt_q),
      .duty_we (duty_we),
      .wr_data (wr_data),
      .mask_we (mask_we),
      .mask_din(wr_data[i]),
      .transfer(transfer),
      .pwm_out (pwm_out[i])
    );
  end

  assign commit_pending = pending_q;
  assign wrap_tick      = wrap_tick_q;

endmodule

// File: tb/tb_tt_pwm_bank.sv
// Self-checking bench for tt_pwm_bank against a cycle-level behavioural model.
module tb_tt_pwm_bank;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ena = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             commit = 1'b0;
  logic             commit_pending;
  logic             wrap_tick;
  logic [NCH-1:0]   pwm_out;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  int         m_cnt, m_per_sh, m_per_act, m_mask_sh, m_mask_act;
  int         m_duty_sh [NCH];
  int         m_duty_act[NCH];
  bit         m_pend, m_wrap;
  bit [NCH-1:0] m_pwm;

  tt_pwm_bank #(
    .NCH  (NCH),
    .WIDTH(WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .commit_pending(commit_pending),
    .wrap_tick     (wrap_tick),
    .pwm_out       (pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_cnt = 0; m_per_sh = 0; m_per_act = 0; m_mask_sh = 0; m_mask_act = 0;
    m_pend = 0; m_wrap = 0; m_pwm = '0;
    for (int i = 0; i < NCH; i++) begin
      m_duty_sh[i] = 0;
      m_duty_act[i] = 0;
    end
  endtask

  // Drive one cycle and advance the model by the same edge.
  task automatic cyc(input bit e, input bit we, input int a, input int d, input bit c, input bit r);
    bit end_of_period;
    ena = e; wr_en = we; wr_addr = a[AW-1:0]; wr_data = d[WIDTH-1:0]; commit = c; rst = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      end_of_period = e && (m_cnt == m_per_act);
      for (int i = 0; i < NCH; i++)
        m_pwm[i] = e && m_mask_act[i] && (m_cnt < m_duty_act[i]);
      m_wrap = end_of_period;
      if (end_of_period && m_pend) begin
        m_per_act  = m_per_sh;
        m_mask_act = m_mask_sh;
        for (int i = 0; i < NCH; i++) m_duty_act[i] = m_duty_sh[i];
        m_pend = 0;
      end
      if (c) m_pend = 1;
      if (we) begin
        if (a == 0) m_per_sh = d % 256;
        else if (a >= 1 && a <= NCH) m_duty_sh[a-1] = d % 256;
        else if (a == NCH + 1) m_mask_sh = d % (1 << NCH);
      end
      if (e) m_cnt = end_of_period ? 0 : m_cnt + 1;
    end
    #1;
    wr_en = 0; commit = 0; rst = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic align_cnt(input int target);
    int guard = 0;
    while (m_cnt != target && guard < 300) begin
      cyc(1, 0, 0, 0, 0, 0);
      guard++;
    end
    if (m_cnt != target) begin
      total++;
      $display("FAIL align_cnt: counter never reached %0d", target);
    end
  endtask

  task automatic wait_commit_done(input string tag);
    int guard = 0;
    while (commit_pending === 1'b1 && guard < 300) begin
      cyc(1, 0, 0, 0, 0, 0);
      guard++;
    end
    total++;
    if (commit_pending !== 1'b0) $display("FAIL %s_commit_clear: pending=%b expected 0", tag, commit_pending);
    else passed++;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, 1);
    total++;
    if ({commit_pending, wrap_tick, pwm_out} !== '0)
      $display("FAIL reset_outputs: got pend=%b wrap=%b pwm=%b expected all 0", commit_pending, wrap_tick, pwm_out);
    else passed++;
  endtask

  task automatic test_basic();
    cyc(0, 1, 0, 4, 0, 0);
    cyc(0, 1, 1, 2, 0, 0);
    cyc(0, 1, NCH + 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    total++;
    if (commit_pending !== 1'b1) $display("FAIL basic_pending_set: got %b expected 1", commit_pending);
    else passed++;
    cyc(1, 0, 0, 0, 0, 0);
    total++;
    if (commit_pending !== 1'b0 || wrap_tick !== 1'b1)
      $display("FAIL basic_first_wrap: pend=%b wrap=%b expected 0/1", commit_pending, wrap_tick);
    else passed++;
    for (int k = 0; k < 15; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (pwm_out !== {3'b000, (k % 5) < 2} || wrap_tick !== ((k % 5) == 4))
        $display("FAIL basic_pattern[%0d]: pwm=%b wrap=%b expected pwm0=%0d wrap=%0d",
                 k, pwm_out, wrap_tick, (k % 5) < 2, (k % 5) == 4);
      else passed++;
    end
  endtask

  task automatic test_duty_edges();
    int duties[3] = '{0, 5, 255};
    for (int j = 0; j < 3; j++) begin
      cyc(1, 1, 1, duties[j], 0, 0);
      cyc(1, 0, 0, 0, 1, 0);
      wait_commit_done("duty_edge");
      for (int k = 0; k < 8; k++) begin
        cyc(1, 0, 0, 0, 0, 0);
        total++;
        if (pwm_out[0] !== (duties[j] != 0))
          $display("FAIL duty_edge_%0d[%0d]: pwm0=%b expected %0d", duties[j], k, pwm_out[0], duties[j] != 0);
        else passed++;
      end
    end
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    wait_commit_done("period0");
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (pwm_out[0] !== 1'b1 || wrap_tick !== 1'b1)
        $display("FAIL period0[%0d]: pwm0=%b wrap=%b expected 1/1", k, pwm_out[0], wrap_tick);
      else passed++;
    end
  endtask

  task automatic test_midperiod();
    bit exp_seq[10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0};
    cyc(1, 1, 0, 4, 0, 0);
    cyc(1, 1, 1, 2, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    wait_commit_done("mid_setup");
    align_cnt(0);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) cyc(1, 1, 1, 4, 0, 0);
      else if (k == 1) cyc(1, 0, 0, 0, 1, 0);
      else cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (pwm_out[0] !== exp_seq[k])
        $display("FAIL midperiod[%0d]: pwm0=%b expected %0d", k, pwm_out[0], exp_seq[k]);
      else passed++;
    end
  endtask

  task automatic test_no_commit();
    cyc(1, 1, 1, 3, 0, 0);
    cyc(1, 1, NCH + 1, 15, 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (pwm_out !== m_pwm || pwm_out[3:1] !== 3'b000)
        $display("FAIL no_commit[%0d]: pwm=%b expected %b", k, pwm_out, m_pwm);
      else passed++;
    end
    cyc(1, 1, 7, 200, 0, 0);
    cyc(1, 1, 6, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    wait_commit_done("oob");
    for (int k = 0; k < 10; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (pwm_out !== {3'b000, (k % 5) < 3})
        $display("FAIL oob_addr[%0d]: pwm=%b expected %b", k, pwm_out, {3'b000, (k % 5) < 3});
      else passed++;
    end
  endtask

  task automatic test_ena_drop();
    align_cnt(1);
    cyc(1, 1, 1, 2, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      total++;
      if (pwm_out !== '0 || wrap_tick !== 1'b0 || commit_pending !== 1'b1)
        $display("FAIL ena_low[%0d]: pwm=%b wrap=%b pend=%b expected 0/0/1", k, pwm_out, wrap_tick, commit_pending);
      else passed++;
    end
    cyc(1, 0, 0, 0, 0, 0);
    total++;
    if (pwm_out[0] !== 1'b1) $display("FAIL ena_resume_cnt2: pwm0=%b expected 1", pwm_out[0]);
    else passed++;
    cyc(1, 0, 0, 0, 0, 0);
    total++;
    if (pwm_out[0] !== 1'b0) $display("FAIL ena_resume_cnt3: pwm0=%b expected 0", pwm_out[0]);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (pwm_out !== m_pwm || wrap_tick !== m_wrap || commit_pending !== m_pend)
        $display("FAIL ena_after[%0d]: pwm=%b wrap=%b pend=%b expected %b/%b/%b",
                 k, pwm_out, wrap_tick, commit_pending, m_pwm, m_wrap, m_pend);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 1, 1, 4, 0, 0);
    align_cnt(0);
    cyc(1, 0, 0, 0, 1, 0);
    run(2);
    total++;
    if (m_cnt != 3 || commit_pending !== 1'b1)
      $display("FAIL reset_mid_setup: pend=%b expected 1", commit_pending);
    else passed++;
    cyc(1, 0, 0, 0, 0, 1);
    total++;
    if (pwm_out !== '0 || wrap_tick !== 1'b0 || commit_pending !== 1'b0)
      $display("FAIL reset_mid: pwm=%b wrap=%b pend=%b expected 0/0/0", pwm_out, wrap_tick, commit_pending);
    else passed++;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (pwm_out !== '0 || commit_pending !== 1'b0 || wrap_tick !== 1'b1)
        $display("FAIL reset_after[%0d]: pwm=%b pend=%b wrap=%b expected 0/0/1", k, pwm_out, commit_pending, wrap_tick);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      bit e, we, c, r;
      int a, d;
      e  = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 9) < 3);
      a  = $urandom_range(0, 7);
      if (a == 0) d = $urandom_range(0, 9);
      else if ($urandom_range(0, 7) == 0) d = 255;
      else d = $urandom_range(0, 12);
      c  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 199) == 0);
      cyc(e, we, a, d, c, r);
      total++;
      if (pwm_out !== m_pwm || wrap_tick !== m_wrap || commit_pending !== m_pend)
        $display("FAIL random[%0d]: pwm=%b wrap=%b pend=%b expected %b/%b/%b",
                 k, pwm_out, wrap_tick, commit_pending, m_pwm, m_wrap, m_pend);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_duty_edges();
    test_midperiod();
    test_no_commit();
    test_ena_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
